// File: rtl/jrb_bus_pkg.sv
// -----------------------------------------------------------------------------
// jrb_bus_pkg
// Shared constants for the jrb8 bus datapath.
// - Destination codes (in_sel) are fixed.
// - Source codes (out_sel) depend on the GP register count, so they are
//   provided as functions of num_gp.
// - pc_width() derives the program-counter width from the data width.
// No ports (package).
// -----------------------------------------------------------------------------
package jrb_bus_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int PC_W       = 2 * DEF_DATA_W;

    // Destination codes (in_sel)
    localparam int DST_NONE = 0;
    localparam int DST_OUT  = 1;
    localparam int DST_MARL = 2;
    localparam int DST_MARH = 3;
    localparam int DST_JL   = 4;
    localparam int DST_JH   = 5;
    localparam int DST_GP0  = 6;

    // Source codes (out_sel): 0 is ext_in, 1..num_gp are the GP registers
    localparam int SRC_EXT  = 0;
    localparam int SRC_GP0  = 1;

    function automatic int src_alu(input int num_gp);
        return num_gp + 1;
    endfunction

    function automatic int src_rom(input int num_gp);
        return num_gp + 2;
    endfunction

    function automatic int src_ram(input int num_gp);
        return num_gp + 3;
    endfunction

    function automatic int src_pcl(input int num_gp);
        return num_gp + 4;
    endfunction

    function automatic int src_pch(input int num_gp);
        return num_gp + 5;
    endfunction

    function automatic int dst_gp_last(input int num_gp);
        return DST_GP0 + num_gp - 1;
    endfunction

    // Both code spaces need this many distinct values
    function automatic int codes_needed(input int num_gp);
        return num_gp + 6;
    endfunction

    function automatic int pc_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/jrb_bus_datapath_if.sv
// -----------------------------------------------------------------------------
// jrb_bus_datapath_if
// Bus/handshake bundle between the control side (master) and the datapath
// (slave).
// Control -> datapath:
//   ena, in_sel, out_sel, pc_inc, jmp_cond, ext_in, alu_data, rom_data,
//   ram_data, out_ready
// Datapath -> control:
//   bus, gp_flat, pc, mar, out_data, out_valid, stall, bus_err
// -----------------------------------------------------------------------------
interface jrb_bus_datapath_if #(
    parameter int DATA_W = 8,
    parameter int NUM_GP = 3,
    parameter int SEL_W  = 4
);
    logic                     ena;
    logic [SEL_W-1:0]         in_sel;
    logic [SEL_W-1:0]         out_sel;
    logic                     pc_inc;
    logic                     jmp_cond;
    logic [DATA_W-1:0]        ext_in;
    logic [DATA_W-1:0]        alu_data;
    logic [DATA_W-1:0]        rom_data;
    logic [DATA_W-1:0]        ram_data;
    logic [DATA_W-1:0]        bus;
    logic [NUM_GP*DATA_W-1:0] gp_flat;
    logic [2*DATA_W-1:0]      pc;
    logic [2*DATA_W-1:0]      mar;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     stall;
    logic                     bus_err;

    modport master (
        output ena, in_sel, out_sel, pc_inc, jmp_cond,
        output ext_in, alu_data, rom_data, ram_data, out_ready,
        input  bus, gp_flat, pc, mar, out_data, out_valid, stall, bus_err
    );

    modport slave (
        input  ena, in_sel, out_sel, pc_inc, jmp_cond,
        input  ext_in, alu_data, rom_data, ram_data, out_ready,
        output bus, gp_flat, pc, mar, out_data, out_valid, stall, bus_err
    );

endinterface

// File: rtl/jrb_pc_unit.sv
// -----------------------------------------------------------------------------
// jrb_pc_unit
// Program counter with a staged conditional jump.
// - A DST_JL write loads the jump low byte into jmp_lo.
// - A DST_JH write with jmp_cond=1 loads pc <= {bus, jmp_lo}.
// - Otherwise pc_inc advances pc by one, wrapping at all-ones.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   upd         update permitted this cycle (ena & ~stall)
//   wr_jl       bus destination is the jump low staging register
//   wr_jh       bus destination is the jump high byte
//   jmp_cond    jump condition
//   pc_inc      increment request
//   bus_val     current databus value
//   pc          program counter
// -----------------------------------------------------------------------------
module jrb_pc_unit
    import jrb_bus_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          upd,
    input  logic                          wr_jl,
    input  logic                          wr_jh,
    input  logic                          jmp_cond,
    input  logic                          pc_inc,
    input  logic [DATA_W-1:0]             bus_val,
    output logic [pc_width(DATA_W)-1:0]   pc
);

    localparam int PC_BITS = pc_width(DATA_W);

    logic [DATA_W-1:0] jmp_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= '0;
            jmp_lo <= '0;
        end else if (upd) begin
            if (wr_jl) begin
                jmp_lo <= bus_val;
            end
            // A taken jump wins over pc_inc; an untaken one falls through.
            // jmp_lo is left alone so it can be reused by a later jump.
            if (wr_jh && jmp_cond) begin
                pc <= {bus_val, jmp_lo};
            end else if (pc_inc) begin
                pc <= pc + PC_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/jrb_bus_datapath.sv
// -----------------------------------------------------------------------------
// jrb_bus_datapath
// Shared databus mux, NUM_GP general registers, program counter (jrb_pc_unit),
// 2-byte memory address register and an output register with a valid/ready
// handshake toward the display path.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bif    jrb_bus_datapath_if.slave: select codes, pc control, data sources,
//          output handshake in; bus, registers, stall and bus_err out
// -----------------------------------------------------------------------------
module jrb_bus_datapath
    import jrb_bus_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_GP = 3,
    parameter int SEL_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    jrb_bus_datapath_if.slave   bif
);

    localparam int PC_BITS = pc_width(DATA_W);

    generate
        if (codes_needed(NUM_GP) > (2 ** SEL_W)) begin : g_sel_check
            $error("jrb_bus_datapath: SEL_W too small for NUM_GP");
        end
    endgenerate

    logic [DATA_W-1:0]  gp [NUM_GP];
    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] mar;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic [DATA_W-1:0]  bus_v;
    logic               src_err;
    logic               dst_err;
    logic               stall;
    logic               upd;
    int                 osel;
    int                 isel;

    assign osel = int'({{(32-SEL_W){1'b0}}, bif.out_sel});
    assign isel = int'({{(32-SEL_W){1'b0}}, bif.in_sel});

    // Source mux; unmapped codes drive zero and flag an error
    always_comb begin
        bus_v   = '0;
        src_err = 1'b0;
        if (osel == SRC_EXT) begin
            bus_v = bif.ext_in;
        end else if (osel <= NUM_GP) begin
            for (int k = 0; k < NUM_GP; k++) begin
                if (osel == SRC_GP0 + k) begin
                    bus_v = gp[k];
                end
            end
        end else if (osel == src_alu(NUM_GP)) begin
            bus_v = bif.alu_data;
        end else if (osel == src_rom(NUM_GP)) begin
            bus_v = bif.rom_data;
        end else if (osel == src_ram(NUM_GP)) begin
            bus_v = bif.ram_data;
        end else if (osel == src_pcl(NUM_GP)) begin
            bus_v = pc[DATA_W-1:0];
        end else if (osel == src_pch(NUM_GP)) begin
            bus_v = pc[PC_BITS-1:DATA_W];
        end else begin
            src_err = 1'b1;
        end
    end

    assign dst_err = (isel > dst_gp_last(NUM_GP));

    // A full output register blocks the whole datapath until it drains
    assign stall = bif.ena & (isel == DST_OUT) & out_valid & ~bif.out_ready;
    assign upd   = bif.ena & ~stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_GP; k++) begin
                gp[k] <= '0;
            end
            mar <= '0;
        end else if (upd) begin
            for (int k = 0; k < NUM_GP; k++) begin
                if (isel == DST_GP0 + k) begin
                    gp[k] <= bus_v;
                end
            end
            if (isel == DST_MARL) begin
                mar[DATA_W-1:0] <= bus_v;
            end
            if (isel == DST_MARH) begin
                mar[PC_BITS-1:DATA_W] <= bus_v;
            end
        end
    end

    // A new write takes priority over the drain, giving zero-bubble
    // throughput; the drain itself ignores ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (upd && (isel == DST_OUT)) begin
            out_data  <= bus_v;
            out_valid <= 1'b1;
        end else if (out_valid && bif.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    jrb_pc_unit #(
        .DATA_W (DATA_W)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd      (upd),
        .wr_jl    (isel == DST_JL),
        .wr_jh    (isel == DST_JH),
        .jmp_cond (bif.jmp_cond),
        .pc_inc   (bif.pc_inc),
        .bus_val  (bus_v),
        .pc       (pc)
    );

    always_comb begin
        bif.gp_flat = '0;
        for (int k = 0; k < NUM_GP; k++) begin
            bif.gp_flat[k*DATA_W +: DATA_W] = gp[k];
        end
    end

    assign bif.bus       = bus_v;
    assign bif.pc        = pc;
    assign bif.mar       = mar;
    assign bif.out_data  = out_data;
    assign bif.out_valid = out_valid;
    assign bif.stall     = stall;
    assign bif.bus_err   = src_err | dst_err;

endmodule

// File: tb/tb_jrb_bus_datapath.sv
// -----------------------------------------------------------------------------
// tb_jrb_bus_datapath
// Directed test of jrb_bus_datapath with DATA_W=8, NUM_GP=3, SEL_W=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// or one further time unit later for combinational paths.
// -----------------------------------------------------------------------------
module tb_jrb_bus_datapath;

    localparam int DATA_W = 8;
    localparam int NUM_GP = 3;
    localparam int SEL_W  = 4;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    jrb_bus_datapath_if #(.DATA_W(DATA_W), .NUM_GP(NUM_GP), .SEL_W(SEL_W)) bif ();

    jrb_bus_datapath #(
        .DATA_W (DATA_W),
        .NUM_GP (NUM_GP),
        .SEL_W  (SEL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.ena       = 1'b1;
        bif.in_sel    = 4'd0;
        bif.out_sel   = 4'd0;
        bif.pc_inc    = 1'b0;
        bif.jmp_cond  = 1'b0;
        bif.out_ready = 1'b0;
    endtask

    // Move value v through ext_in into destination d
    task automatic write_ext(input logic [3:0] d, input logic [7:0] v);
        bif.out_sel = 4'd0;
        bif.ext_in  = v;
        bif.in_sel  = d;
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        bif.ext_in   = 8'h00;
        bif.alu_data = 8'h11;
        bif.rom_data = 8'h22;
        bif.ram_data = 8'h33;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Dirty some state, then reset with a write in flight
        write_ext(4'd6, 8'h5A);
        bif.pc_inc  = 1'b1;
        bif.out_sel = 4'd1;
        bif.in_sel  = 4'd1;
        tick();
        check("pre_gp0", 32'(bif.gp_flat[7:0]), 32'h5A);
        check("pre_out", 32'({bif.out_valid, bif.out_data}), 32'h15A);
        bif.pc_inc = 1'b0;
        rst_n      = 1'b0;
        write_ext(4'd6, 8'h77);
        rst_n = 1'b1;
        idle();
        check("rst_gp", 32'(bif.gp_flat), 32'h0);
        check("rst_pc", 32'(bif.pc), 32'h0);
        check("rst_mar", 32'(bif.mar), 32'h0);
        check("rst_out_data", 32'(bif.out_data), 32'h0);
        check("rst_out_valid", 32'(bif.out_valid), 32'h0);

        // Basic transfer ext -> GP0 -> bus
        write_ext(4'd6, 8'h3C);
        bif.in_sel  = 4'd0;
        bif.out_sel = 4'd1;
        #1;
        check("xfer_bus", 32'(bif.bus), 32'h3C);
        check("xfer_err", 32'(bif.bus_err), 32'h0);

        // Fixed sources
        bif.out_sel = 4'd4; #1;
        check("src_alu", 32'(bif.bus), 32'h11);
        bif.out_sel = 4'd5; #1;
        check("src_rom", 32'(bif.bus), 32'h22);
        bif.out_sel = 4'd6; #1;
        check("src_ram", 32'(bif.bus), 32'h33);

        // Taken jump wins over pc_inc
        write_ext(4'd4, 8'h34);
        bif.jmp_cond = 1'b1;
        bif.pc_inc   = 1'b1;
        write_ext(4'd5, 8'h12);
        check("jmp_taken", 32'(bif.pc), 32'h1234);
        // Untaken jump: pc_inc still applies
        bif.jmp_cond = 1'b0;
        write_ext(4'd5, 8'h56);
        check("jmp_not_taken", 32'(bif.pc), 32'h1235);
        bif.pc_inc = 1'b0;
        bif.in_sel = 4'd0;
        bif.out_sel = 4'd7; #1;
        check("src_pcl", 32'(bif.bus), 32'h35);
        bif.out_sel = 4'd8; #1;
        check("src_pch", 32'(bif.bus), 32'h12);

        // PC wrap
        write_ext(4'd4, 8'hFF);
        bif.jmp_cond = 1'b1;
        write_ext(4'd5, 8'hFF);
        check("pc_ffff", 32'(bif.pc), 32'hFFFF);
        bif.jmp_cond = 1'b0;
        bif.in_sel   = 4'd0;
        bif.pc_inc   = 1'b1;
        tick();
        check("pc_wrap0", 32'(bif.pc), 32'h0000);
        tick();
        check("pc_wrap1", 32'(bif.pc), 32'h0001);
        bif.pc_inc = 1'b0;

        // MAR
        write_ext(4'd2, 8'hAB);
        write_ext(4'd3, 8'hCD);
        check("mar", 32'(bif.mar), 32'hCDAB);

        // Output backpressure
        bif.out_ready = 1'b0;
        write_ext(4'd1, 8'hA1);
        check("out_first", 32'({bif.out_valid, bif.out_data}), 32'h1A1);
        bif.ext_in = 8'hB2;
        bif.pc_inc = 1'b1;
        #1;
        check("stall_on", 32'(bif.stall), 32'h1);
        tick();
        check("stall_hold_data", 32'(bif.out_data), 32'hA1);
        check("stall_hold_pc", 32'(bif.pc), 32'h0001);
        bif.out_ready = 1'b1;
        #1;
        check("stall_off", 32'(bif.stall), 32'h0);
        tick();
        check("out_second", 32'({bif.out_valid, bif.out_data}), 32'h1B2);
        check("pc_after_stall", 32'(bif.pc), 32'h0002);
        bif.pc_inc = 1'b0;
        bif.ext_in = 8'h01;
        #1;
        check("b2b_nostall1", 32'(bif.stall), 32'h0);
        tick();
        check("b2b_data1", 32'(bif.out_data), 32'h01);
        bif.ext_in = 8'h02;
        #1;
        check("b2b_nostall2", 32'(bif.stall), 32'h0);
        tick();
        check("b2b_data2", 32'({bif.out_valid, bif.out_data}), 32'h102);
        bif.in_sel = 4'd0;
        tick();
        check("drain", 32'({bif.out_valid, bif.out_data}), 32'h002);
        bif.out_ready = 1'b0;

        // Unmapped codes
        bif.out_sel = 4'd9; #1;
        check("bad_src_bus", 32'(bif.bus), 32'h0);
        check("bad_src_err", 32'(bif.bus_err), 32'h1);
        bif.out_sel = 4'd0;
        bif.ext_in  = 8'hEE;
        bif.in_sel  = 4'd15;
        #1;
        check("bad_dst_err", 32'(bif.bus_err), 32'h1);
        tick();
        check("bad_dst_gp", 32'(bif.gp_flat), 32'h00003C);
        check("bad_dst_mar", 32'(bif.mar), 32'hCDAB);
        check("bad_dst_out", 32'({bif.out_valid, bif.out_data}), 32'h002);
        check("bad_dst_pc", 32'(bif.pc), 32'h0002);

        // ena=0 freezes everything except the handshake clear
        write_ext(4'd1, 8'h77);
        bif.ena    = 1'b0;
        bif.pc_inc = 1'b1;
        bif.ext_in = 8'h99;
        #1;
        check("ena0_nostall", 32'(bif.stall), 32'h0);
        tick();
        tick();
        bif.in_sel = 4'd7;
        tick();
        tick();
        tick();
        check("ena0_pc", 32'(bif.pc), 32'h0002);
        check("ena0_gp", 32'(bif.gp_flat), 32'h00003C);
        check("ena0_out", 32'({bif.out_valid, bif.out_data}), 32'h177);
        bif.out_ready = 1'b1;
        tick();
        check("ena0_drain", 32'({bif.out_valid, bif.out_data}), 32'h077);
        bif.out_ready = 1'b0;
        bif.pc_inc    = 1'b0;
        bif.ena       = 1'b1;
        tick();
        check("ena1_gp1", 32'(bif.gp_flat), 32'h00993C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
